// File: rtl/coffee_pkg.sv
// Shared types and constants for the brew sequencer: FSM states, valve indices,
// the default recipe table and the duration lookup helper.
package coffee_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int ING_WATER     = 0;
  localparam int ING_COFFEE    = 1;
  localparam int ING_SUGAR     = 2;
  localparam int ING_MILK      = 3;
  localparam int ING_CHOCOLATE = 4;

  localparam int DEF_NUM_INGREDIENTS = 5;
  localparam int DEF_NUM_RECIPES     = 4;
  localparam int DEF_TIME_W          = 4;
  localparam logic [DEF_NUM_RECIPES*DEF_NUM_INGREDIENTS*DEF_TIME_W-1:0] DEF_RECIPE_TABLE =
    80'h00233_32011_03112_00022;

  // Widest table the helper accepts; callers zero-extend and truncate the result.
  localparam int MAX_TABLE_W = 1024;

  function automatic logic [31:0] recipe_duration(input logic [MAX_TABLE_W-1:0] tbl,
                                                  input int recipe, input int ing,
                                                  input int num_ing, input int time_w);
    logic [MAX_TABLE_W-1:0] sh;
    sh = tbl >> ((recipe * num_ing + ing) * time_w);
    return sh[31:0];
  endfunction

endpackage

// File: rtl/recipe_rom_module.sv
// Combinational (recipe, step) -> duration-in-seconds lookup into the packed table.
module recipe_rom_module
  import coffee_pkg::*;
#(
  parameter int NUM_INGREDIENTS = DEF_NUM_INGREDIENTS,
  parameter int NUM_RECIPES     = DEF_NUM_RECIPES,
  parameter int TIME_W          = DEF_TIME_W,
  parameter logic [NUM_RECIPES*NUM_INGREDIENTS*TIME_W-1:0] RECIPE_TABLE = DEF_RECIPE_TABLE,
  parameter int RIDX_W          = 2,
  parameter int STEP_W          = 3
) (
  input  logic [RIDX_W-1:0] recipe,
  input  logic [STEP_W-1:0] step,
  output logic [TIME_W-1:0] duration
);

  logic [MAX_TABLE_W-1:0] tbl;

  assign tbl      = MAX_TABLE_W'(RECIPE_TABLE);
  assign duration = TIME_W'(recipe_duration(tbl, int'(recipe), int'(step),
                                            NUM_INGREDIENTS, TIME_W));

endmodule

// File: rtl/recipe_sequencer_module.sv
// Brew sequencer: latches a recipe on start and opens each valve in order for its
// table-defined number of seconds, then pulses finished. All outputs are registered.
module recipe_sequencer_module
  import coffee_pkg::*;
#(
  parameter int NUM_INGREDIENTS = DEF_NUM_INGREDIENTS,
  parameter int NUM_RECIPES     = DEF_NUM_RECIPES,
  parameter int TIME_W          = DEF_TIME_W,
  parameter int TICKS_PER_SEC   = 50_000_000,
  parameter logic [NUM_RECIPES*NUM_INGREDIENTS*TIME_W-1:0] RECIPE_TABLE = DEF_RECIPE_TABLE,
  parameter int RSEL_W          = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [RSEL_W-1:0]                  recipe_sel,
  input  logic                               abort,
  output logic [NUM_INGREDIENTS-1:0]         ingredient_en,
  output logic [$clog2(NUM_INGREDIENTS)-1:0] step,
  output logic [TIME_W-1:0]                  remaining_seconds,
  output logic                               busy,
  output logic                               finished,
  output logic                               error
);

  localparam int STEP_W = $clog2(NUM_INGREDIENTS);
  localparam int RIDX_W = (NUM_RECIPES > 1) ? $clog2(NUM_RECIPES) : 1;
  localparam int PRE_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_INGREDIENTS - 1);
  localparam logic [RSEL_W:0]   NREC      = (RSEL_W + 1)'(NUM_RECIPES);

  state_t              state_q, state_n;
  logic [RIDX_W-1:0]   recipe_q, recipe_n;
  logic [STEP_W-1:0]   step_q, step_n;
  logic [PRE_W-1:0]    pre_q, pre_n;
  logic [TIME_W-1:0]   sec_q, sec_n;
  logic [TIME_W-1:0]   dur_q, dur_n;
  logic                error_n, step_end, valve_n;

  // ROM is addressed by the next recipe/step so the outputs can be registered
  // alongside the state; dur_q then holds the duration of the step in progress.
  recipe_rom_module #(
    .NUM_INGREDIENTS(NUM_INGREDIENTS),
    .NUM_RECIPES    (NUM_RECIPES),
    .TIME_W         (TIME_W),
    .RECIPE_TABLE   (RECIPE_TABLE),
    .RIDX_W         (RIDX_W),
    .STEP_W         (STEP_W)
  ) u_rom (
    .recipe  (recipe_n),
    .step    (step_n),
    .duration(dur_n)
  );

  always_comb begin
    state_n  = state_q;
    recipe_n = recipe_q;
    step_n   = step_q;
    pre_n    = pre_q;
    sec_n    = sec_q;
    error_n  = 1'b0;
    step_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ({1'b0, recipe_sel} < NREC) begin
            recipe_n = recipe_sel[RIDX_W-1:0];
            step_n   = '0;
            pre_n    = '0;
            sec_n    = '0;
            state_n  = RUN;
          end else begin
            error_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          step_n  = '0;
          pre_n   = '0;
          sec_n   = '0;
        end else if (dur_q == '0) begin
          step_end = 1'b1;
        end else if (pre_q == PRE_MAX) begin
          pre_n = '0;
          if (sec_q == dur_q - 1'b1) step_end = 1'b1;
          else                       sec_n    = sec_q + 1'b1;
        end else begin
          pre_n = pre_q + 1'b1;
        end
        if (step_end) begin
          pre_n = '0;
          sec_n = '0;
          if (step_q == LAST_STEP) state_n = DONE;
          else                     step_n  = step_q + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        step_n  = '0;
      end
      default: begin
        state_n = IDLE;
        step_n  = '0;
      end
    endcase
    valve_n = (state_n == RUN) && (dur_n != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      recipe_q          <= '0;
      step_q            <= '0;
      pre_q             <= '0;
      sec_q             <= '0;
      dur_q             <= '0;
      ingredient_en     <= '0;
      step              <= '0;
      remaining_seconds <= '0;
      busy              <= 1'b0;
      finished          <= 1'b0;
      error             <= 1'b0;
    end else begin
      state_q           <= state_n;
      recipe_q          <= recipe_n;
      step_q            <= step_n;
      pre_q             <= pre_n;
      sec_q             <= sec_n;
      dur_q             <= dur_n;
      // sec_n counts whole elapsed seconds, so remaining never reaches 0 while open
      ingredient_en     <= valve_n ? (NUM_INGREDIENTS'(1) << step_n) : '0;
      remaining_seconds <= valve_n ? (dur_n - sec_n) : '0;
      step              <= step_n;
      busy              <= (state_n != IDLE);
      finished          <= (state_n == DONE);
      error             <= error_n;
    end
  end

endmodule

// File: tb/tb_recipe_sequencer_module.sv
// Randomized self-checking bench for recipe_sequencer_module against a per-cycle
// trace model built from the recipe table (TICKS_PER_SEC = 2).
module tb_recipe_sequencer_module;

  localparam int NI  = 5;
  localparam int NR  = 4;
  localparam int TW  = 4;
  localparam int TPS = 2;
  localparam int RW  = 3;
  localparam logic [79:0] TBL = 80'h00233_32011_03112_00022;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [RW-1:0] recipe_sel = '0;
  logic [NI-1:0] ingredient_en;
  logic [2:0]    step;
  logic [TW-1:0] remaining_seconds;
  logic          busy, finished, error;

  int n_chk  = 0;
  int n_fail = 0;
  int f;

  always #5 clock = ~clock;

  recipe_sequencer_module #(
    .NUM_INGREDIENTS(NI),
    .NUM_RECIPES    (NR),
    .TIME_W         (TW),
    .TICKS_PER_SEC  (TPS),
    .RECIPE_TABLE   (TBL),
    .RSEL_W         (RW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .recipe_sel       (recipe_sel),
    .abort            (abort),
    .ingredient_en    (ingredient_en),
    .step             (step),
    .remaining_seconds(remaining_seconds),
    .busy             (busy),
    .finished         (finished),
    .error            (error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur(input int r, input int i);
    logic [79:0] t;
    t = TBL >> ((r * NI + i) * TW);
    return int'(t[3:0]);
  endfunction

  // Cycles from acceptance to the finished pulse.
  function automatic int brew_len(input int r);
    int n = 1;
    for (int i = 0; i < NI; i++) n += (dur(r, i) > 0) ? dur(r, i) * TPS : 1;
    return n;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_en"},   32'(ingredient_en), 0);
    chk({tag, "_rem"},  32'(remaining_seconds), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fin"},  32'(finished), 0);
    chk({tag, "_step"}, 32'(step), 0);
  endtask

  // abort_at > 0: abort during that cycle; < 0: abort together with start.
  task automatic run_recipe(input int r, input bit disturb, input int abort_at, output int fin_cyc);
    int q_en[$];
    int q_rem[$];
    int q_step[$];
    int n;
    for (int i = 0; i < NI; i++) begin
      int d = dur(r, i);
      if (d == 0) begin
        q_en.push_back(0); q_rem.push_back(0); q_step.push_back(i);
      end else begin
        for (int c = 0; c < d * TPS; c++) begin
          q_en.push_back(1 << i); q_rem.push_back(d - c / TPS); q_step.push_back(i);
        end
      end
    end
    n = q_en.size() + 1;
    fin_cyc = 0;
    start = 1'b1;
    recipe_sel = RW'(r);
    abort = (abort_at < 0);
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      abort = 1'b0;
      if (finished === 1'b1 && fin_cyc == 0) fin_cyc = k;
      if ((abort_at > 0 && k == abort_at + 1) || k == n + 1) begin
        chk_idle("end");
        chk("end_err", 32'(error), 0);
        break;
      end
      chk("run_err",  32'(error), 0);
      chk("run_busy", 32'(busy), 1);
      if (k < n) begin
        chk("run_en",   32'(ingredient_en), 32'(q_en[k-1]));
        chk("run_rem",  32'(remaining_seconds), 32'(q_rem[k-1]));
        chk("run_step", 32'(step), 32'(q_step[k-1]));
        chk("run_fin",  32'(finished), 0);
      end else begin
        chk("done_en",  32'(ingredient_en), 0);
        chk("done_rem", 32'(remaining_seconds), 0);
        chk("done_fin", 32'(finished), 1);
      end
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        recipe_sel = RW'($urandom);
      end
      if (k == abort_at) abort = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic bad_start(input logic [RW-1:0] s);
    start = 1'b1;
    recipe_sel = s;
    @(posedge clock); #1;
    start = 1'b0;
    chk("err_pulse", 32'(error), 1);
    chk("err_busy",  32'(busy), 0);
    chk("err_en",    32'(ingredient_en), 0);
    @(posedge clock); #1;
    chk("err_clear", 32'(error), 0);
    chk("err_busy2", 32'(busy), 0);
    chk("err_en2",   32'(ingredient_en), 0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #11;
    chk_idle("rst");
    chk("rst_err", 32'(error), 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    run_recipe(0, 1'b0, 0, f);
    chk("lat_r0", f, 12);
    run_recipe(2, 1'b0, 0, f);
    chk("lat_r2", f, 16);
    bad_start(3'd5);
    run_recipe(1, 1'b1, 0, f);
    chk("lat_r1_disturbed", f, 16);

    run_recipe(3, 1'b0, 6, f);
    chk("abort_no_fin", f, 0);
    @(posedge clock); #1;
    chk_idle("abort_gap");
    run_recipe(3, 1'b0, 0, f);
    chk("lat_r3", f, 19);
    run_recipe(2, 1'b0, -1, f);
    chk("lat_abort_start", f, 16);

    // asynchronous reset between clock edges mid-brew
    start = 1'b1; recipe_sel = 3'd0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_err", 32'(error), 0);
    @(negedge clock) reset = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      chk_idle("post_rst");
    end
    run_recipe(0, 1'b0, 0, f);
    chk("lat_after_rst", f, 12);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        bad_start(RW'($urandom_range(NR, 7)));
      end else begin
        int r, ab;
        r  = $urandom_range(0, NR - 1);
        ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, brew_len(r)) : 0;
        run_recipe(r, 1'($urandom_range(0, 1)), ab, f);
        if (ab == 0) chk("lat_rand", f, brew_len(r));
        else if (ab < brew_len(r)) chk("abort_rand_no_fin", f, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
